knn_seq_ctrl: RTL

Parametrised sequencing controller for the KNN accelerator, the successor of the fixed 128-point / 32-cycle controller. Tracks train-point loading, test-point capture and the cyclic sort sweep, and drives the memory write, test-register and smallest-data-register controls. It sits between the input handshake and the train memory / sorter datapath. Over the previous controller it adds generic depth and sort length, a saturating sort counter, test-flag clearing, abort, a ready/drop handshake and status counters.

---
 rtl/knn_pkg.sv | 22 ++
 rtl/knn_sat_counter.sv | 33 +++
 rtl/knn_seq_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// knn_pkg
// Shared definitions for the KNN accelerator control slice.
//   knn_state_t      : 3-bit controller state encoding (codes 4-7 unused)
//   KNN_N_TRAIN      : default number of train points held in memory
//   KNN_SORT_CYCLES  : default length of one sort sweep in cycles
//   TYPE_TRAIN/TEST  : values of the input data-type bit
package knn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_SORT = 3'd2,
    ST_DONE = 3'd3
  } knn_state_t;

  localparam int KNN_N_TRAIN     = 128;
  localparam int KNN_SORT_CYCLES = 32;

  localparam logic TYPE_TRAIN = 1'b0;
  localparam logic TYPE_TEST  = 1'b1;

endpackage

// File: rtl/knn_sat_counter.sv
// knn_sat_counter
// Up-counter that stops at MAX; a clear request wins over an increment.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, count returns to 0
//   inc   : advance by one unless already at MAX
//   clr   : return to 0 (priority over inc)
//   count : current value
module knn_sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Count register: clear first, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/knn_seq_ctrl.sv
// knn_seq_ctrl
// Sequencing controller for the KNN accelerator. Loads train points into
// memory, captures the test point, then runs a fixed-length cyclic sort
// sweep over memory and presents the result until new input arrives.
// Ports:
//   clk, rst                 : clock (rising edge), async active-high reset
//   i_valid, i_data_type     : input word strobe and kind (0 train, 1 test)
//   i_train_points_update    : discard the train set (DONE only)
//   i_abort                  : abandon the running search (ARM/SORT only)
//   o_ready, o_drop          : word accepted / word ignored while busy
//   o_wr_rq, o_wr_source     : train memory write and its source (1 = sort)
//   o_wr_test_point_en       : load the test-point register
//   o_sorting_indication     : a sort cycle is active
//   o_clr_smallest_data_regs : clear the sorter result registers
//   o_valid, o_busy          : result valid (DONE) / search running (ARM, SORT)
//   o_current_state          : raw state code
//   o_train_count            : train points received, saturating at N_TRAIN
//   o_sort_count             : sort cycles elapsed in the current sweep
module knn_seq_ctrl
  import knn_pkg::*;
#(
  parameter int N_TRAIN     = KNN_N_TRAIN,
  parameter int SORT_CYCLES = KNN_SORT_CYCLES,
  parameter int CNT_W       = $clog2(N_TRAIN + 1),
  parameter int SRT_W       = $clog2(SORT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_data_type,
  input  logic             i_train_points_update,
  input  logic             i_abort,
  output logic             o_ready,
  output logic             o_drop,
  output logic             o_wr_rq,
  output logic             o_wr_source,
  output logic             o_wr_test_point_en,
  output logic             o_sorting_indication,
  output logic             o_clr_smallest_data_regs,
  output logic             o_valid,
  output logic             o_busy,
  output logic [2:0]       o_current_state,
  output logic [CNT_W-1:0] o_train_count,
  output logic [SRT_W-1:0] o_sort_count
);

  localparam logic [CNT_W-1:0] TRAIN_FULL = CNT_W'(N_TRAIN);
  localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(N_TRAIN - 1);
  localparam logic [SRT_W-1:0] SORT_LAST  = SRT_W'(SORT_CYCLES - 1);

  knn_state_t       state;
  knn_state_t       next_state;
  logic             test_flag;
  logic [CNT_W-1:0] train_cnt;
  logic [SRT_W-1:0] sort_cnt;

  logic train_inc;
  logic train_clr;
  logic sort_inc;
  logic sort_clr;
  logic tf_set;
  logic tf_clr;
  logic is_test;
  logic full_now;
  logic full_after;

  assign is_test    = (i_data_type == TYPE_TEST);
  // "Full after this cycle" lets the last train word trigger ARM directly
  // when the test point was captured before the train set completed.
  assign full_now   = (train_cnt == TRAIN_FULL);
  assign full_after = full_now || (train_cnt == TRAIN_LAST);

  knn_sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (N_TRAIN)
  ) u_train_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (train_inc),
    .clr   (train_clr),
    .count (train_cnt)
  );

  knn_sat_counter #(
    .WIDTH (SRT_W),
    .MAX   (SORT_CYCLES)
  ) u_sort_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (sort_inc),
    .clr   (sort_clr),
    .count (sort_cnt)
  );

  // Next-state decode plus all control outputs. Outputs are combinational
  // from state, counters and inputs so the datapath sees them in the same
  // cycle the word is presented.
  always_comb begin
    next_state               = state;
    train_inc                = 1'b0;
    train_clr                = 1'b0;
    sort_inc                 = 1'b0;
    sort_clr                 = 1'b0;
    tf_set                   = 1'b0;
    tf_clr                   = 1'b0;
    o_ready                  = 1'b0;
    o_wr_rq                  = 1'b0;
    o_wr_source              = 1'b0;
    o_wr_test_point_en       = 1'b0;
    o_sorting_indication     = 1'b0;
    o_clr_smallest_data_regs = 1'b0;
    o_valid                  = 1'b0;
    o_busy                   = 1'b0;

    case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          if (is_test) begin
            o_wr_test_point_en = 1'b1;
            tf_set             = 1'b1;
            if (full_now) begin
              next_state = ST_ARM;
            end
          end else begin
            // Writes continue once full; the counter simply holds.
            o_wr_rq   = 1'b1;
            train_inc = 1'b1;
            if (full_after && test_flag) begin
              next_state = ST_ARM;
            end
          end
        end
      end

      ST_ARM: begin
        o_busy                   = 1'b1;
        o_clr_smallest_data_regs = 1'b1;
        sort_clr                 = 1'b1;
        if (i_abort) begin
          tf_clr     = 1'b1;
          next_state = ST_IDLE;
        end else begin
          next_state = ST_SORT;
        end
      end

      ST_SORT: begin
        o_busy = 1'b1;
        if (i_abort) begin
          o_clr_smallest_data_regs = 1'b1;
          sort_clr                 = 1'b1;
          tf_clr                   = 1'b1;
          next_state               = ST_IDLE;
        end else begin
          o_wr_rq              = 1'b1;
          o_wr_source          = 1'b1;
          o_sorting_indication = 1'b1;
          if (sort_cnt == SORT_LAST) begin
            sort_clr   = 1'b1;
            next_state = ST_DONE;
          end else begin
            sort_inc = 1'b1;
          end
        end
      end

      ST_DONE: begin
        o_ready = 1'b1;
        o_valid = 1'b1;
        if (i_train_points_update) begin
          o_clr_smallest_data_regs = 1'b1;
          train_clr                = 1'b1;
          tf_clr                   = 1'b1;
          next_state               = ST_IDLE;
          // A test word arriving with the update starts the new train set
          // with its test point already in place.
          if (i_valid && is_test) begin
            o_wr_test_point_en = 1'b1;
            tf_set             = 1'b1;
          end
        end else if (i_valid && is_test) begin
          o_wr_test_point_en = 1'b1;
          next_state         = ST_ARM;
        end else if (i_valid) begin
          o_wr_rq    = 1'b1;
          next_state = ST_ARM;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Ignored words are flagged rather than silently lost.
  assign o_drop          = i_valid && !o_ready;
  assign o_current_state = state;
  assign o_train_count   = train_cnt;
  assign o_sort_count    = sort_cnt;

  // State and test-flag register. Setting the flag wins over clearing it so
  // an update-with-test-word in DONE leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      test_flag <= 1'b0;
    end else begin
      state <= next_state;
      if (tf_set) begin
        test_flag <= 1'b1;
      end else if (tf_clr) begin
        test_flag <= 1'b0;
      end
    end
  end

endmodule
